// File: rtl/spi_master_ctrl.sv
// SPI master that issues RAM-access frames (write-addr/write-data/read-addr/read-data) and captures read bytes.
// Optional SPI_MASTER_RDCHK_EN flags a read-data frame not preceded by a completed read-addr frame via rsp_err.
module spi_master_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int RD_GAP    = 2,
    parameter int IDLE_GAP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_SIZE-1:0] cmd_data,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int FRAME_W  = ADDR_SIZE + 2;
    localparam int CNT_W    = $clog2(FRAME_W);
    localparam int CAP_W    = ADDR_SIZE - 1;
    localparam int WAIT_MAX = (RD_GAP > IDLE_GAP) ? RD_GAP : IDLE_GAP;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0]  OUT_LAST     = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  IN_LAST      = CNT_W'(ADDR_SIZE - 1);
    localparam logic [WAIT_W-1:0] RD_WAIT_INIT = WAIT_W'((RD_GAP > 1) ? RD_GAP - 2 : 0);
    localparam logic [WAIT_W-1:0] GAP_INIT     = WAIT_W'(IDLE_GAP - 1);

    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SELECT    = 3'd1;
    localparam logic [2:0] CHAN      = 3'd2;
    localparam logic [2:0] SHIFT_OUT = 3'd3;
    localparam logic [2:0] WAIT_RD   = 3'd4;
    localparam logic [2:0] SHIFT_IN  = 3'd5;
    localparam logic [2:0] GAP       = 3'd6;

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [WAIT_W-1:0]    wcnt;
    logic [1:0]           op_r;
    logic [FRAME_W-1:0]   shreg;
    logic [CAP_W-1:0]     cap;
    logic [ADDR_SIZE-1:0] payload;
    logic                 rd_err;

    // Read-data frames carry an all-zero payload regardless of cmd_data.
    assign payload = (cmd_op == OP_RD_DATA) ? {ADDR_SIZE{1'b0}} : cmd_data;

`ifdef SPI_MASTER_RDCHK_EN
    logic rd_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_armed <= 1'b0;
        end else if (state == SHIFT_OUT && cnt == '0 && op_r == OP_RD_ADDR) begin
            rd_armed <= 1'b1;
        end else if (state == SHIFT_IN && cnt == '0) begin
            rd_armed <= 1'b0;
        end
    end

    assign rd_err = ~rd_armed;
`else
    assign rd_err = 1'b0;
`endif

    // Every output is a flop written on the transition into the state that owns its value.
    always_ff @(posedge clk) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wcnt      <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        shreg     <= {cmd_op, payload};
                        op_r      <= cmd_op;
                        state     <= SELECT;
                        SS_n      <= 1'b0;
                        MOSI      <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SELECT: begin
                    state <= CHAN;
                    MOSI  <= op_r[1];
                end
                CHAN: begin
                    state <= SHIFT_OUT;
                    MOSI  <= shreg[FRAME_W-1];
                    shreg <= {shreg[FRAME_W-2:0], 1'b0};
                    cnt   <= OUT_LAST;
                end
                SHIFT_OUT: begin
                    if (cnt != '0) begin
                        MOSI  <= shreg[FRAME_W-1];
                        shreg <= {shreg[FRAME_W-2:0], 1'b0};
                        cnt   <= cnt - 1'b1;
                    end else begin
                        MOSI <= 1'b0;
                        if (op_r == OP_RD_DATA) begin
                            if (RD_GAP > 1) begin
                                state <= WAIT_RD;
                                wcnt  <= RD_WAIT_INIT;
                            end else begin
                                state <= SHIFT_IN;
                                cnt   <= IN_LAST;
                            end
                        end else begin
                            state <= GAP;
                            SS_n  <= 1'b1;
                            wcnt  <= GAP_INIT;
                        end
                    end
                end
                WAIT_RD: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        state <= SHIFT_IN;
                        cnt   <= IN_LAST;
                    end
                end
                SHIFT_IN: begin
                    cap <= {cap[CAP_W-2:0], MISO};
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data  <= {cap, MISO};
                        rsp_valid <= 1'b1;
                        rsp_err   <= rd_err;
                        state     <= GAP;
                        SS_n      <= 1'b1;
                        wcnt      <= GAP_INIT;
                    end
                end
                GAP: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: a default instance talking to a behavioural slave/RAM model,
// plus an RD_GAP=3 instance fed a fixed 1010_1010 MISO pattern.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int IDLE_GAP = 1;
`ifdef SPI_MASTER_RDCHK_EN
    localparam logic RDCHK = 1'b1;
`else
    localparam logic RDCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       ss_n, mosi, miso = 1'b0, rsp_valid, rsp_err, busy;
    logic [7:0] rsp_data;

    logic       cmd_valid3 = 1'b0, cmd_ready3;
    logic [1:0] cmd_op3 = 2'b00;
    logic [7:0] cmd_data3 = 8'h00;
    logic       ss_n3, mosi3, miso3 = 1'b0, rsp_valid3, rsp_err3, busy3;
    logic [7:0] rsp_data3;

    spi_master_ctrl #(.ADDR_SIZE(8), .RD_GAP(2), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .SS_n(ss_n), .MOSI(mosi), .MISO(miso), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    spi_master_ctrl #(.ADDR_SIZE(8), .RD_GAP(3), .IDLE_GAP(IDLE_GAP)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
        .cmd_data(cmd_data3), .SS_n(ss_n3), .MOSI(mosi3), .MISO(miso3), .rsp_valid(rsp_valid3),
        .rsp_data(rsp_data3), .rsp_err(rsp_err3), .busy(busy3)
    );

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Slave/RAM model: counts SS_n-low cycles, decodes the frame, returns read bytes on MISO.
    int         k = 0, last_len = 0;
    logic [11:0] seq = '0;
    logic [9:0]  fr = '0;
    logic [7:0]  ram [256];
    logic [7:0]  wr_addr = 8'h00, rd_addr = 8'h00, rd_byte = 8'h00;

    always @(negedge clk) begin
        if (ss_n) begin
            if (k > 0) last_len = k;
            k = 0;
            miso = 1'b0;
        end else begin
            k = k + 1;
            if (k <= 12) seq = {seq[10:0], mosi};
            if (k >= 3 && k <= 12) fr = {fr[8:0], mosi};
            if (k == 12) begin
                case (fr[9:8])
                    2'b00: wr_addr = fr[7:0];
                    2'b01: ram[wr_addr] = fr[7:0];
                    2'b10: rd_addr = fr[7:0];
                    default: rd_byte = ram[rd_addr];
                endcase
            end
            if (k >= 14 && k <= 21) miso = rd_byte[21-k];
            else miso = 1'b0;
        end
    end

    int         k3 = 0, last_len3 = 0;
    logic [7:0] miso_byte3 = 8'hAA;

    always @(negedge clk) begin
        if (ss_n3) begin
            if (k3 > 0) last_len3 = k3;
            k3 = 0;
            miso3 = 1'b0;
        end else begin
            k3 = k3 + 1;
            if (k3 >= 15 && k3 <= 22) miso3 = miso_byte3[22-k3];
            else miso3 = 1'b0;
        end
    end

    // Scoreboard monitors: pop one expected {err, data} per rsp_valid pulse.
    logic [8:0] exp_q[$];
    logic [8:0] exp_q3[$];
    logic       prev_v = 1'b0, prev_v3 = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (prev_v) chk("rsp_single_cycle", rsp_valid, 1'b0);
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected_qsize", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e[7:0]);
                chk("rsp_err", rsp_err, e[8]);
            end
        end
        prev_v = rsp_valid;
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (prev_v3) chk("rsp3_single_cycle", rsp_valid3, 1'b0);
        if (rsp_valid3) begin
            if (exp_q3.size() == 0) begin
                chk("rsp3_unexpected_qsize", exp_q3.size(), 1);
            end else begin
                e = exp_q3.pop_front();
                chk("rsp3_data", rsp_data3, e[7:0]);
                chk("rsp3_err", rsp_err3, e[8]);
            end
        end
        prev_v3 = rsp_valid3;
    end

    // Called at a negedge; returns at the negedge of the SELECT cycle.
    task automatic issue(input bit sel, input logic [1:0] op, input logic [7:0] data);
        bit got = 1'b0;
        if (sel) begin cmd_valid3 = 1'b1; cmd_op3 = op; cmd_data3 = data; end
        else     begin cmd_valid  = 1'b1; cmd_op  = op; cmd_data  = data; end
        for (int i = 0; i < 100; i++) begin
            if ((sel ? cmd_ready3 : cmd_ready) == 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept_timeout", got, 1'b1);
        if (got) @(posedge clk);
        @(negedge clk);
        if (sel) cmd_valid3 = 1'b0;
        else     cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel ? busy3 : busy) == 1'b0) begin done = 1'b1; break; end
        end
        chk("idle_timeout", done, 1'b1);
    endtask

    int rise, rdy;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0] = 8'h3C;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ss_n", ss_n, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Read-data with no prior read-addr; payload must be zeros even though cmd_data=FF
        exp_q.push_back({RDCHK, 8'h3C});
        issue(1'b0, 2'b11, 8'hFF);
        wait_idle(1'b0);
        chk("rd_nochk_seq", seq, 12'h700);
        chk("rd_nochk_len", last_len, 21);

        // Write-addr 0x5A: SELECT 0, chan 0, then 00_01011010
        issue(1'b0, 2'b00, 8'h5A);
        wait_idle(1'b0);
        chk("wa_len", last_len, 12);
        chk("wa_mosi_seq", seq, 12'h05A);

        // Round trip through the RAM model
        issue(1'b0, 2'b00, 8'h10); wait_idle(1'b0);
        issue(1'b0, 2'b01, 8'hC3); wait_idle(1'b0);
        chk("rt_wd_len", last_len, 12);
        issue(1'b0, 2'b10, 8'h10); wait_idle(1'b0);
        exp_q.push_back({1'b0, 8'hC3});
        issue(1'b0, 2'b11, 8'h00); wait_idle(1'b0);
        chk("rt_rd_len", last_len, 21);

        // Back-to-back with cmd_valid held high
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h21;
        rdy = -1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin rdy = i; break; end
            @(negedge clk);
        end
        chk("b2b_first_ready", rdy >= 0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_op = 2'b01; cmd_data = 8'h77;
        rise = -1; rdy = -1;
        for (int i = 0; i < 100; i++) begin
            if (rise < 0 && ss_n) rise = i;
            if (cmd_ready) begin rdy = i; break; end
            @(negedge clk);
        end
        chk("b2b_ready_low_frame1", rdy, 13);
        chk("b2b_gap", rdy - rise, IDLE_GAP);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_second_accept", ss_n, 1'b0);
        cmd_valid = 1'b0;
        wait_idle(1'b0);
        chk("b2b_second_len", last_len, 12);
        chk("b2b_ram_write", ram[8'h21], 8'h77);

        // Reset in cycle 5 of a read-data frame
        issue(1'b0, 2'b11, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ss_n", ss_n, 1'b1);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_rsp_data", rsp_data, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        repeat (30) @(negedge clk);
        chk("midrst_rsp_data_hold", rsp_data, 8'h00);

        // Recovery after the abandoned frame
        issue(1'b0, 2'b10, 8'h10); wait_idle(1'b0);
        exp_q.push_back({1'b0, 8'hC3});
        issue(1'b0, 2'b11, 8'h00); wait_idle(1'b0);

        // RD_GAP=3 instance with 1,0,1,0,... on MISO
        exp_q3.push_back({RDCHK, 8'hAA});
        issue(1'b1, 2'b11, 8'h00);
        wait_idle(1'b1);
        chk("g3_len", last_len3, 22);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp_q3_drained", exp_q3.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
